// File: rtl/session_tick_if.sv
// Handshake and control bundle between a session owner and session_tick_ctrl.
// The master drives requests; the slave (the controller) returns status.
interface session_tick_if #(
  parameter int unsigned CNT_W = 26,
  parameter int unsigned TMO_W = 8
);
  logic             cfg_valid;
  logic [CNT_W-1:0] cfg_div;
  logic             cfg_ready;
  logic             start;
  logic             stop;
  logic             activity;
  logic [TMO_W-1:0] tmo_limit;
  logic             tick;
  logic             tmo_warn;
  logic             tmo_expired;
  logic             busy;

  modport master (
    output cfg_valid, cfg_div, start, stop, activity, tmo_limit,
    input  cfg_ready, tick, tmo_warn, tmo_expired, busy
  );

  modport slave (
    input  cfg_valid, cfg_div, start, stop, activity, tmo_limit,
    output cfg_ready, tick, tmo_warn, tmo_expired, busy
  );
endinterface

// File: rtl/session_tick_ctrl.sv
// Programmable tick prescaler with a session-timeout FSM (IDLE/RUN/EXPIRED).
// Divisor updates in RUN are deferred to the next tick edge so periods never glitch.
module session_tick_ctrl #(
  parameter int unsigned CNT_W       = 26,
  parameter int unsigned DEFAULT_DIV = 500000,
  parameter int unsigned TMO_W       = 8,
  parameter int unsigned WARN_TICKS  = 5
) (
  input logic           clk,
  input logic           rst_n,
  session_tick_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRun, StExpired} state_e;

  localparam logic [CNT_W-1:0] DivReset = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] DivMin   = CNT_W'(2);
  localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);
  localparam logic [TMO_W-1:0] TmoOne   = TMO_W'(1);
  localparam logic [TMO_W:0]   WarnThr  = (TMO_W+1)'(WARN_TICKS);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] pre_q, pre_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic [TMO_W-1:0] tcnt_q, tcnt_d;
  logic [TMO_W-1:0] lim_q, lim_d;
  logic             tick_q, tick_d;
  logic             warn_q, warn_d;
  logic             exp_q, exp_d;
  logic             rdy_q, rdy_d;

  logic [CNT_W-1:0] cfg_div_clamped;
  logic [TMO_W-1:0] tcnt_inc;
  logic [TMO_W:0]   remain;
  logic             cfg_acc;
  logic             tick_edge;
  logic             start_only;

  assign cfg_div_clamped = (bus.cfg_div < DivMin) ? DivMin : bus.cfg_div;
  assign cfg_acc         = bus.cfg_valid & rdy_q;
  assign tick_edge       = (state_q == StRun) && (pre_q == (div_q - CntOne));
  assign start_only      = bus.start & ~bus.stop;
  // Saturate so a disabled timeout never wraps back toward the warning window.
  assign tcnt_inc        = (tcnt_q == '1) ? tcnt_q : tcnt_q + TmoOne;

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    pre_d      = pre_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    tcnt_d     = tcnt_q;
    lim_d      = lim_q;
    tick_d     = 1'b0;
    exp_d      = exp_q;
    rdy_d      = rdy_q;
    remain     = '0;

    unique case (state_q)
      StIdle: begin
        pre_d  = '0;
        tcnt_d = '0;
        if (cfg_acc) div_d = cfg_div_clamped;
        if (start_only) begin
          state_d = StRun;
          lim_d   = bus.tmo_limit;
        end
      end
      StRun: begin
        if (cfg_acc) begin
          pend_d     = cfg_div_clamped;
          pend_vld_d = 1'b1;
          rdy_d      = 1'b0;
        end
        if (start_only) begin
          pre_d  = '0;
          tcnt_d = '0;
          lim_d  = bus.tmo_limit;
          if (pend_vld_q) begin
            div_d      = pend_q;
            pend_vld_d = 1'b0;
            rdy_d      = 1'b1;
          end
        end else if (tick_edge) begin
          pre_d  = '0;
          tick_d = 1'b1;
          if (pend_vld_q) begin
            div_d      = pend_q;
            pend_vld_d = 1'b0;
            rdy_d      = 1'b1;
          end
          if (bus.activity) begin
            tcnt_d = '0;
          end else begin
            tcnt_d = tcnt_inc;
            if ((lim_q != '0) && (tcnt_inc == lim_q)) begin
              state_d = StExpired;
              exp_d   = 1'b1;
            end
          end
        end else begin
          pre_d = pre_q + CntOne;
          if (bus.activity) tcnt_d = '0;
        end
      end
      StExpired: begin
        pre_d = '0;
        if (cfg_acc) div_d = cfg_div_clamped;
        if (start_only) begin
          state_d = StRun;
          exp_d   = 1'b0;
          tcnt_d  = '0;
          lim_d   = bus.tmo_limit;
        end
      end
      default: state_d = StIdle;
    endcase

    // Stop overrides everything; a pending or same-cycle divisor lands in div.
    if (bus.stop) begin
      state_d    = StIdle;
      pre_d      = '0;
      tcnt_d     = '0;
      exp_d      = 1'b0;
      tick_d     = 1'b0;
      if (cfg_acc)         div_d = cfg_div_clamped;
      else if (pend_vld_q) div_d = pend_q;
      pend_vld_d = 1'b0;
      rdy_d      = 1'b1;
    end

    remain = {1'b0, lim_d} - {1'b0, tcnt_d};
    warn_d = (state_d == StRun) && (lim_d != '0) && (remain <= WarnThr);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      div_q      <= DivReset;
      pre_q      <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      tcnt_q     <= '0;
      lim_q      <= '0;
      tick_q     <= 1'b0;
      warn_q     <= 1'b0;
      exp_q      <= 1'b0;
      rdy_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      pre_q      <= pre_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      tcnt_q     <= tcnt_d;
      lim_q      <= lim_d;
      tick_q     <= tick_d;
      warn_q     <= warn_d;
      exp_q      <= exp_d;
      rdy_q      <= rdy_d;
    end
  end

  assign bus.tick        = tick_q;
  assign bus.tmo_warn    = warn_q;
  assign bus.tmo_expired = exp_q;
  assign bus.cfg_ready   = rdy_q;
  assign bus.busy        = (state_q == StRun);

endmodule

// File: tb/tb_session_tick_ctrl.sv
// Directed bench for session_tick_ctrl; expectations are hand-derived cycle tables
// where cycle N means the cycle after the N-th edge following the start edge.
module tb_session_tick_ctrl;

  localparam int unsigned CntW = 26;
  localparam int unsigned TmoW = 8;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  session_tick_if #(.CNT_W(CntW), .TMO_W(TmoW)) bus_if ();

  session_tick_ctrl #(
    .CNT_W      (CntW),
    .DEFAULT_DIV(4),
    .TMO_W      (TmoW),
    .WARN_TICKS (1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Start is sampled at the next edge (E0); returns in cycle 0.
  task automatic pulse_start(input logic [TmoW-1:0] lim);
    bus_if.tmo_limit = lim;
    bus_if.start     = 1'b1;
    cyc();
    bus_if.start     = 1'b0;
  endtask

  task automatic pulse_stop();
    bus_if.stop = 1'b1;
    cyc();
    bus_if.stop = 1'b0;
  endtask

  task automatic offer_div(input logic [CntW-1:0] d);
    bus_if.cfg_valid = 1'b1;
    bus_if.cfg_div   = d;
    cyc();
    bus_if.cfg_valid = 1'b0;
  endtask

  task automatic check_idle_flags(input string tag);
    check_eq({tag, " tick"}, 32'(bus_if.tick), 0);
    check_eq({tag, " warn"}, 32'(bus_if.tmo_warn), 0);
    check_eq({tag, " expired"}, 32'(bus_if.tmo_expired), 0);
    check_eq({tag, " busy"}, 32'(bus_if.busy), 0);
    check_eq({tag, " ready"}, 32'(bus_if.cfg_ready), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    bus_if.cfg_valid = 1'b0;
    bus_if.cfg_div   = '0;
    bus_if.start     = 1'b0;
    bus_if.stop      = 1'b0;
    bus_if.activity  = 1'b0;
    bus_if.tmo_limit = '0;
    cyc();
    cyc();
    check_idle_flags("reset");
    rst_n = 1'b1;
    cyc();

    // Default divisor 4, free-running.
    pulse_start(8'd0);
    for (int i = 1; i <= 13; i++) begin
      cyc();
      check_eq($sformatf("t1 tick c%0d", i), 32'(bus_if.tick), 32'((i % 4) == 0));
      check_eq($sformatf("t1 busy c%0d", i), 32'(bus_if.busy), 1);
      check_eq($sformatf("t1 ready c%0d", i), 32'(bus_if.cfg_ready), 1);
    end
    pulse_stop();
    check_eq("t1 stop busy", 32'(bus_if.busy), 0);

    // Timeout 3 ticks, no activity.
    pulse_start(8'd3);
    for (int i = 1; i <= 16; i++) begin
      cyc();
      check_eq($sformatf("t2 tick c%0d", i), 32'(bus_if.tick), 32'(i == 4 || i == 8 || i == 12));
      check_eq($sformatf("t2 warn c%0d", i), 32'(bus_if.tmo_warn), 32'(i >= 8 && i < 12));
      check_eq($sformatf("t2 exp c%0d", i), 32'(bus_if.tmo_expired), 32'(i >= 12));
      check_eq($sformatf("t2 busy c%0d", i), 32'(bus_if.busy), 32'(i < 12));
    end
    pulse_start(8'd3);
    check_eq("t2 restart exp", 32'(bus_if.tmo_expired), 0);
    check_eq("t2 restart busy", 32'(bus_if.busy), 1);
    for (int i = 1; i <= 4; i++) begin
      cyc();
      check_eq($sformatf("t2r tick c%0d", i), 32'(bus_if.tick), 32'(i == 4));
    end
    pulse_stop();

    // Activity on tick 2 (E8) and six cycles later (E14); expiry three ticks on.
    pulse_start(8'd3);
    for (int i = 1; i <= 28; i++) begin
      cyc();
      check_eq($sformatf("t3 tick c%0d", i), 32'(bus_if.tick), 32'((i % 4) == 0 && i <= 24));
      check_eq($sformatf("t3 warn c%0d", i), 32'(bus_if.tmo_warn), 32'(i >= 20 && i < 24));
      check_eq($sformatf("t3 exp c%0d", i), 32'(bus_if.tmo_expired), 32'(i >= 24));
      if (i == 8 || i == 14) check_eq($sformatf("t3 tcnt c%0d", i), 32'(dut.tcnt_q), 0);
      if (i == 12) check_eq("t3 tcnt c12", 32'(dut.tcnt_q), 1);
      if (i == 20) check_eq("t3 tcnt c20", 32'(dut.tcnt_q), 2);
      bus_if.activity = (i == 7 || i == 13);
    end
    pulse_stop();

    // Divisor 10, change to 3 offered in cycle 4 (accepted at E5).
    offer_div(26'd10);
    check_eq("t4 idle ready", 32'(bus_if.cfg_ready), 1);
    pulse_start(8'd0);
    bus_if.cfg_div = 26'd3;
    for (int i = 1; i <= 17; i++) begin
      cyc();
      check_eq($sformatf("t4 tick c%0d", i), 32'(bus_if.tick), 32'(i == 10 || i == 13 || i == 16));
      check_eq($sformatf("t4 ready c%0d", i), 32'(bus_if.cfg_ready), 32'(!(i >= 5 && i <= 9)));
      bus_if.cfg_valid = (i == 4);
    end
    pulse_stop();

    // Clamp: divisor 0 becomes 2.
    offer_div(26'd0);
    pulse_start(8'd0);
    for (int i = 1; i <= 8; i++) begin
      cyc();
      check_eq($sformatf("t5 tick c%0d", i), 32'(bus_if.tick), 32'((i % 2) == 0));
    end

    // Start and stop together while running: stop wins.
    bus_if.start = 1'b1;
    bus_if.stop  = 1'b1;
    cyc();
    bus_if.start = 1'b0;
    bus_if.stop  = 1'b0;
    check_eq("t6 busy", 32'(bus_if.busy), 0);
    cyc();
    cyc();
    cyc();
    check_eq("t6 busy later", 32'(bus_if.busy), 0);
    check_eq("t6 tick later", 32'(bus_if.tick), 0);

    // Reset with a pending divisor discards it and restores the default.
    pulse_start(8'd0);
    offer_div(26'd6);
    check_eq("t7 pending ready", 32'(bus_if.cfg_ready), 0);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    check_idle_flags("t7 reset");
    pulse_start(8'd0);
    for (int i = 1; i <= 8; i++) begin
      cyc();
      check_eq($sformatf("t7 tick c%0d", i), 32'(bus_if.tick), 32'((i % 4) == 0));
    end
    pulse_stop();

    // Stop with a pending divisor applies it.
    pulse_start(8'd0);
    offer_div(26'd5);
    check_eq("t8 pending ready", 32'(bus_if.cfg_ready), 0);
    pulse_stop();
    check_eq("t8 stop ready", 32'(bus_if.cfg_ready), 1);
    pulse_start(8'd0);
    for (int i = 1; i <= 10; i++) begin
      cyc();
      check_eq($sformatf("t8 tick c%0d", i), 32'(bus_if.tick), 32'((i % 5) == 0));
    end
    pulse_stop();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/session_tick_ctrl.md
# session_tick_ctrl

Programmable tick scheduler and session-timeout controller for the ATM vending machine. It replaces free-running derived clocks with a single-cycle `tick` clock-enable whose period can be reconfigured at run time through a valid/ready handshake. A session timeout FSM counts ticks since the last user activity, raises a warning near the limit, and flags expiry so the transaction FSM can eject or abort. All downstream logic stays on `clk`.

## Interface
- `CNT_W`, 26, width of prescaler and divisor
- `DEFAULT_DIV`, 500000, divisor loaded at reset (cycles per tick)
- `TMO_W`, 8, width of timeout limit and tick counter
- `WARN_TICKS`, 5, ticks-remaining threshold for `tmo_warn`
- `clk`  in  1  system clock; sole clock
- `rst_n`  in  1  synchronous, active-low reset
- `cfg_valid`  in  1  divisor update request
- `cfg_div`  in  CNT_W  requested divisor
- `cfg_ready`  out  1  controller can accept a divisor update
- `start`  in  1  pulse: begin or restart a session
- `stop`  in  1  pulse: end session, return to IDLE
- `activity`  in  1  pulse: user keypress/card event, reloads timeout
- `tmo_limit`  in  TMO_W  timeout in ticks, latched at `start`; 0 disables timeout
- `tick`  out  1  one-cycle enable, every `div` cycles while RUN
- `tmo_warn`  out  1  level: timeout imminent
- `tmo_expired`  out  1  sticky: session timed out
- `busy`  out  1  high in RUN

## Operation
- States: IDLE, RUN, EXPIRED.
- IDLE: prescaler `pre` = 0, tick counter `tcnt` = 0, `tick` = 0. `start` -> RUN.
- RUN: `pre` increments each cycle; at `pre == div-1`, `pre` <= 0 and `tick` <= 1 for one cycle. Each tick increments `tcnt`.
- `activity` in RUN sets `tcnt` <= 0. If it coincides with a tick, activity wins and `tcnt` = 0.
- Expiry occurs when `lim_q != 0` and a tick takes `tcnt` to `lim_q`. At the edge of that tick, the block enters EXPIRED, sets `tmo_expired` <= 1, and still emits that final tick.
- EXPIRED: no ticks and `pre` is held at 0. `start` -> RUN and clears `tmo_expired`. `activity` is ignored.
- `stop` in any state -> IDLE and clears `pre`, `tcnt` and `tmo_expired`. If `stop` and `start` are asserted together, `stop` wins.
- `start` in RUN restarts the session: `pre` = 0, `tcnt` = 0, `tmo_limit` is re-latched.
- `tmo_warn` = RUN && `lim_q != 0` && (`lim_q` - `tcnt`) <= WARN_TICKS. The subtraction is done in TMO_W+1 bits and is never negative.
- `lim_q` = 0: ticks free-run, `tmo_warn` and `tmo_expired` stay 0, and `tcnt` saturates at all-ones with no wrap.
- Divisor handshake: an update is accepted on a cycle with `cfg_valid && cfg_ready`.
  - In IDLE or EXPIRED: `div` <= `cfg_div` at that edge, and `cfg_ready` stays 1.
  - In RUN: the value is held in a pending register and `cfg_ready` <= 0. The pending value is applied at the next tick edge, where `pre` wraps to 0. `cfg_ready` returns to 1 on that same edge.
  - `stop` with an update pending applies the pending value on entering IDLE.
- Clamp: `cfg_div` < 2 is stored as 2, giving a minimum tick period of 2 cycles.

## Timing
- Reset (`rst_n` = 0 at an edge): state IDLE, `div` = DEFAULT_DIV, `pre` = 0, `tcnt` = 0, `lim_q` = 0, pending register cleared.
  - Outputs: `tick` = 0, `tmo_warn` = 0, `tmo_expired` = 0, `busy` = 0, `cfg_ready` = 1.
  - Reset mid-session discards any pending divisor.
- All outputs are registered. `busy` rises the cycle after `start` is sampled.
- `start` sampled at edge E0: the first `tick` is high in the cycle after edge E(div). Later ticks follow every `div` cycles.
- A divisor change in RUN never produces a short or long period. The period in progress completes with the old `div`, and the next period uses the new one.
- Expiry edge: `tick` = 1 and `tmo_expired` = 1 appear in the same cycle, `busy` drops to 0, and `tmo_warn` drops to 0.
- `activity` sampled at edge E affects `tcnt`, and therefore `tmo_warn`, after E.

## Test plan
- Reset, `div` = DEFAULT_DIV overridden to 4, `start`:
  - Required: ticks at cycles 4, 8, 12 after start; `busy` = 1 from cycle 1; `cfg_ready` = 1 throughout.
- `div` = 4, `tmo_limit` = 3, WARN_TICKS = 1, no activity:
  - Required: `tmo_warn` rises after tick 2.
  - Required: tick 3 at cycle 12 coincides with `tmo_expired` = 1, then no further ticks.
  - Then `start` -> `tmo_expired` clears and ticks resume 4 cycles later.
- `tmo_limit` = 3, `activity` pulsed on the cycle of tick 2 and again 6 cycles later:
  - Required: no expiry; `tcnt` reads 0 after each activity; expiry occurs 3 ticks after the last activity.
- RUN with `div` = 10; `cfg_div` = 3 offered at cycle 4:
  - Required: `cfg_ready` drops, the current period still ends at cycle 10, then ticks follow at 13, 16.
  - Required: `cfg_ready` = 1 again after cycle 10.
- Divisor clamp: `cfg_div` = 0 in IDLE, then `start` -> ticks every 2 cycles.
- Boundary events:
  - `start` and `stop` in the same cycle during RUN -> IDLE.
  - `rst_n` low mid-period with an update pending -> `div` = DEFAULT_DIV, `cfg_ready` = 1, all flags 0.
